// File: rtl/rx_pkt_rd_sched.sv
// rx_pkt_rd_sched: read scheduler that drains complete symbol packets from the harden_rx output buffer.
// Ports: eth_clk/rst_n are the clock and asynchronous active-low reset. enable, clear_err and pkt_ready
// are control and event inputs. sink_ready is downstream readiness. din_valid/din_sop/din_eop carry the
// buffer beat framing. data_rd_req is the buffer read request. busy, pending and status (gp_status)
// report the scheduler state.
module rx_pkt_rd_sched #(
    parameter int MAX_PENDING = 16,
    parameter int BEAT_NUM    = 819,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic        eth_clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        clear_err,
    input  logic        pkt_ready,
    input  logic        sink_ready,
    input  logic        din_valid,
    input  logic        din_sop,
    input  logic        din_eop,
    output logic        data_rd_req,
    output logic        busy,
    output logic [7:0]  pending,
    output logic [31:0] status
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, GAP = 2'd2} state_t;
    state_t      state;
    state_t      after_pkt;
    logic [15:0] beat_cnt;
    logic [15:0] to_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] pkt_done;
    logic [16:0] beat_next;
    logic        err_overflow, err_timeout, err_len, err_sop;
    logic        beat, done, tmo, inc, dec, full, gap_end, sop_err, len_err;
    assign beat      = (state == READ) && din_valid;
    assign beat_next = {1'b0, beat_cnt} + 17'd1;
    assign done      = beat && din_eop;
    // Only cycles where downstream could accept data count toward the timeout.
    assign tmo       = (state == READ) && !din_valid && sink_ready && (to_cnt == 16'(TIMEOUT - 1));
    assign inc       = pkt_ready;
    assign dec       = done || tmo;
    assign full      = pending == 8'(MAX_PENDING);
    assign gap_end   = gap_cnt == 16'(GAP_CYCLES - 1);
    assign after_pkt = (GAP_CYCLES == 0) ? IDLE : GAP;
    // sop must appear on the first beat and only there.
    assign sop_err   = beat && (din_sop ? (|beat_cnt) : ~(|beat_cnt));
    assign len_err   = done && (beat_next != 17'(BEAT_NUM));
    assign data_rd_req = (state == READ) && sink_ready;
    assign busy        = state != IDLE;
    assign status      = {pkt_done, err_sop, err_len, err_timeout, err_overflow, 2'b00, state, pending};
    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            pkt_done     <= '0;
            pending      <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
            err_len      <= 1'b0;
            err_sop      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && |pending) begin
                        state    <= READ;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                    end
                end
                READ: begin
                    if (beat) begin
                        // Saturate so an overlong packet can never wrap back to a legal length.
                        beat_cnt <= &beat_cnt ? beat_cnt : beat_cnt + 16'd1;
                        to_cnt   <= '0;
                    end else if (sink_ready) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                    if (dec) begin
                        state   <= after_pkt;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (done) begin
                pkt_done <= pkt_done + 16'd1;
            end
            if (inc && !dec) begin
                if (!full) begin
                    pending <= pending + 8'd1;
                end
            end else if (dec && !inc) begin
                pending <= pending - 8'd1;
            end
            // A new error in the clear cycle wins so no event is lost.
            err_overflow <= (err_overflow && !clear_err) || (inc && !dec && full);
            err_timeout  <= (err_timeout && !clear_err) || tmo;
            err_len      <= (err_len && !clear_err) || len_err;
            err_sop      <= (err_sop && !clear_err) || sop_err;
        end
    end
endmodule

// File: tb/tb_rx_pkt_rd_sched.sv
// tb_rx_pkt_rd_sched: self-checking bench for rx_pkt_rd_sched (vector table, corner sequences, random vs model).
module tb_rx_pkt_rd_sched;
    localparam int BEAT_NUM    = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int TIMEOUT     = 8;
    localparam int MAX_PENDING = 3;

    logic        eth_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_err = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        sink_ready = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic        data_rd_req;
    logic        busy;
    logic [7:0]  pending;
    logic [31:0] status;

    int checks = 0;
    int failures = 0;

    // Reference model: packet-level bookkeeping derived from the scheduling rules.
    int          m_mode;
    int          m_pend;
    int          m_beats;
    int          m_stall;
    int          m_gap_left;
    logic [15:0] m_done;
    logic [3:0]  m_flags;

    typedef struct {
        logic       en, pr, sr, v, s, e;
        logic [7:0] pend;
        logic [1:0] st;
        logic [3:0] fl;
        logic [15:0] done;
        logic       req;
    } vec_t;
    vec_t vecs[9];

    always #5 eth_clk = ~eth_clk;

    rx_pkt_rd_sched #(
        .MAX_PENDING(MAX_PENDING),
        .BEAT_NUM(BEAT_NUM),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .eth_clk(eth_clk),
        .rst_n(rst_n),
        .enable(enable),
        .clear_err(clear_err),
        .pkt_ready(pkt_ready),
        .sink_ready(sink_ready),
        .din_valid(din_valid),
        .din_sop(din_sop),
        .din_eop(din_eop),
        .data_rd_req(data_rd_req),
        .busy(busy),
        .pending(pending),
        .status(status)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0;
        m_pend = 0;
        m_beats = 0;
        m_stall = 0;
        m_gap_left = 0;
        m_done = '0;
        m_flags = '0;
    endfunction

    task automatic model_step();
        bit         dec = 1'b0;
        logic [3:0] nf = '0;
        int         mode_n = m_mode;
        case (m_mode)
            0: if (enable && m_pend > 0) begin
                mode_n = 1;
                m_beats = 0;
                m_stall = 0;
            end
            1: if (din_valid) begin
                if (din_sop ? m_beats != 0 : m_beats == 0) nf[3] = 1'b1;
                m_beats++;
                m_stall = 0;
                if (din_eop) begin
                    if (m_beats != BEAT_NUM) nf[2] = 1'b1;
                    dec = 1'b1;
                    m_done++;
                    mode_n = (GAP_CYCLES == 0) ? 0 : 2;
                    m_gap_left = GAP_CYCLES;
                end
            end else if (sink_ready) begin
                m_stall++;
                if (m_stall == TIMEOUT) begin
                    nf[1] = 1'b1;
                    dec = 1'b1;
                    mode_n = (GAP_CYCLES == 0) ? 0 : 2;
                    m_gap_left = GAP_CYCLES;
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) mode_n = 0;
            end
        endcase
        if (pkt_ready && !dec) begin
            if (m_pend == MAX_PENDING) nf[0] = 1'b1;
            else m_pend++;
        end else if (dec && !pkt_ready) begin
            m_pend--;
        end
        m_flags = (m_flags & ~{4{clear_err}}) | nf;
        m_mode = mode_n;
    endtask

    function automatic logic [41:0] model_out();
        return {(m_mode == 1) && sink_ready, m_mode != 0, 8'(m_pend), m_done, m_flags, 2'b00, 2'(m_mode), 8'(m_pend)};
    endfunction

    task automatic tick();
        @(posedge eth_clk);
        model_step();
        #1;
        chk("model", 64'({data_rd_req, busy, pending, status}), 64'(model_out()));
        clear_err = 1'b0;
        pkt_ready = 1'b0;
        din_valid = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
    endtask

    task automatic wait_mode(input int m);
        int k = 0;
        while (m_mode != m && k < 60) begin
            tick();
            k++;
        end
        chk("wait_mode", 64'(m_mode), 64'(m));
    endtask

    task automatic run_pkt(input int n, input int sop2, input bit pr_eop, input int en_off);
        wait_mode(1);
        for (int b = 0; b < n; b++) begin
            din_valid = 1'b1;
            din_sop = (b == 0) || (b == sop2);
            din_eop = (b == n - 1);
            pkt_ready = pr_eop && (b == n - 1);
            if (b == en_off) enable = 1'b0;
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{en:1, pr:1, sr:1, v:0, s:0, e:0, pend:1, st:0, fl:0, done:0, req:0};
        vecs[1] = '{en:1, pr:0, sr:1, v:0, s:0, e:0, pend:1, st:1, fl:0, done:0, req:1};
        vecs[2] = '{en:1, pr:0, sr:1, v:1, s:1, e:0, pend:1, st:1, fl:0, done:0, req:1};
        vecs[3] = '{en:1, pr:0, sr:1, v:1, s:0, e:0, pend:1, st:1, fl:0, done:0, req:1};
        vecs[4] = '{en:1, pr:0, sr:1, v:1, s:0, e:0, pend:1, st:1, fl:0, done:0, req:1};
        vecs[5] = '{en:1, pr:0, sr:1, v:1, s:0, e:1, pend:0, st:2, fl:0, done:1, req:0};
        vecs[6] = '{en:1, pr:0, sr:1, v:0, s:0, e:0, pend:0, st:2, fl:0, done:1, req:0};
        vecs[7] = '{en:1, pr:0, sr:1, v:0, s:0, e:0, pend:0, st:0, fl:0, done:1, req:0};
        vecs[8] = '{en:1, pr:0, sr:1, v:1, s:1, e:1, pend:0, st:0, fl:0, done:1, req:0};

        model_reset();
        #1;
        chk("reset", 64'({data_rd_req, busy, pending, status}), 64'(0));
        @(posedge eth_clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            enable = vecs[i].en;
            pkt_ready = vecs[i].pr;
            sink_ready = vecs[i].sr;
            din_valid = vecs[i].v;
            din_sop = vecs[i].s;
            din_eop = vecs[i].e;
            tick();
            chk($sformatf("vec%0d", i), 64'({data_rd_req, pending, status[15:12], status[9:8], status[31:16]}),
                64'({vecs[i].req, vecs[i].pend, vecs[i].fl, vecs[i].st, vecs[i].done}));
        end

        enable = 1'b0;
        repeat (7) begin
            pkt_ready = 1'b1;
            tick();
        end
        chk("ovf_pend", 64'(pending), 64'(3));
        chk("ovf_flag", 64'(status[12]), 64'(1));
        enable = 1'b1;
        repeat (3) run_pkt(4, -1, 1'b0, -1);
        wait_mode(0);
        chk("drain", 64'({pending, status[31:16]}), 64'({8'd0, 16'd4}));
        clear_err = 1'b1;
        tick();
        chk("clear", 64'(status[15:12]), 64'(0));

        pkt_ready = 1'b1;
        tick();
        wait_mode(1);
        repeat (7) tick();
        chk("to_pre", 64'({status[13], status[9:8]}), 64'({1'b0, 2'd1}));
        tick();
        chk("to_hit", 64'({status[13], pending, status[9:8], status[31:16]}), 64'({1'b1, 8'd0, 2'd2, 16'd4}));
        repeat (2) tick();
        chk("to_idle", 64'(status[9:8]), 64'(0));

        clear_err = 1'b1;
        pkt_ready = 1'b1;
        tick();
        wait_mode(1);
        sink_ready = 1'b0;
        repeat (20) tick();
        chk("stall", 64'({status[13], status[9:8], data_rd_req}), 64'({1'b0, 2'd1, 1'b0}));
        sink_ready = 1'b1;
        run_pkt(4, -1, 1'b0, -1);
        wait_mode(0);

        pkt_ready = 1'b1;
        tick();
        run_pkt(3, -1, 1'b0, -1);
        chk("short", 64'(status[15:14]), 64'(2'b01));
        wait_mode(0);
        clear_err = 1'b1;
        pkt_ready = 1'b1;
        tick();
        run_pkt(5, 2, 1'b0, -1);
        chk("long_sop", 64'(status[15:14]), 64'(2'b11));
        clear_err = 1'b1;
        tick();
        wait_mode(0);

        pkt_ready = 1'b1;
        tick();
        run_pkt(4, -1, 1'b1, -1);
        chk("simul", 64'({pending, status[31:16]}), 64'({8'd1, 16'd8}));
        pkt_ready = 1'b1;
        tick();
        run_pkt(4, -1, 1'b0, 1);
        chk("en_off_done", 64'({pending, status[31:16]}), 64'({8'd1, 16'd9}));
        wait_mode(0);
        repeat (6) tick();
        chk("en_off_idle", 64'({busy, pending, status[9:8]}), 64'({1'b0, 8'd1, 2'd0}));

        enable = 1'b1;
        wait_mode(1);
        din_valid = 1'b1;
        din_sop = 1'b1;
        tick();
        din_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 64'({data_rd_req, busy, pending, status}), 64'(0));
        din_valid = 1'b0;
        model_reset();
        @(posedge eth_clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_after", 64'({busy, pending, status[9:8]}), 64'(0));

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            sink_ready = $urandom_range(0, 6) != 0;
            clear_err = $urandom_range(0, 29) == 0;
            pkt_ready = $urandom_range(0, 5) == 0;
            if (m_mode == 1) begin
                din_valid = (c % 500 < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
                din_sop = (m_beats == 0) ^ ($urandom_range(0, 19) == 0);
                din_eop = (m_beats >= BEAT_NUM - 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
            end else begin
                din_valid = $urandom_range(0, 7) == 0;
                din_sop = $urandom_range(0, 1) == 1;
                din_eop = $urandom_range(0, 1) == 1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_pkt_rd_sched.md
Name: rx_pkt_rd_sched

Overview:
- Read scheduler for the harden_rx symbol output buffer, in the eth_clk domain.
- Tracks how many complete per-antenna symbol packets are waiting in the buffer.
- Drives data_rd_req to drain one packet at a time toward pusch_packet or the eth DMA, and checks the returned sop/eop/beat framing.
- Enforces an inter-packet gap, recovers from stalled packets by timeout, and reports status through a gp_status word.

Parameters:
- MAX_PENDING, 16: pending-packet counter saturation value (max 255).
- BEAT_NUM, 819: expected 64-bit beats per packet (sop through eop inclusive).
- GAP_CYCLES, 4: idle cycles forced after each packet; 0 means no gap.
- TIMEOUT, 1024: cycles without a valid beat while reading before the packet is abandoned.

Ports:
- eth_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scheduler enable (gp_control bit).
- clear_err  in  1  single-cycle pulse; clears sticky error flags.
- pkt_ready  in  1  single-cycle pulse; one complete packet was written to the buffer.
- sink_ready  in  1  downstream can accept data (data_rd_req or m_axis_eth_tready).
- din_valid  in  1  buffer output beat valid.
- din_sop  in  1  buffer output start of packet, qualified by din_valid.
- din_eop  in  1  buffer output end of packet, qualified by din_valid.
- data_rd_req  out  1  read request to the buffer.
- busy  out  1  state is not IDLE.
- pending  out  8  packets waiting, including the one being read.
- status  out  32  gp_status word: [7:0] pending, [9:8] state, [12] err_overflow, [13] err_timeout, [14] err_len, [15] err_sop, [31:16] pkt_done count.

Behaviour:
- Reset: all registers are asynchronously cleared. data_rd_req=0, busy=0, pending=0, status=0, state=IDLE.
- FSM states: IDLE=0, READ=1, GAP=2. All state is registered; data_rd_req is combinational = (state==READ) & sink_ready.
- IDLE -> READ when enable & pending!=0. The beat counter and timeout counter load 0 on entry.
- READ:
  - Each din_valid beat increments the beat counter and clears the timeout counter.
  - When din_valid is low, the timeout counter increments, but only while sink_ready=1 (a downstream stall is not a fault).
  - Packet complete on din_valid & din_eop:
    - err_len is set if (beat count incl. this beat) != BEAT_NUM.
    - pending is decremented and pkt_done is incremented (wraps at 65535).
    - Next state is GAP, or IDLE if GAP_CYCLES==0.
  - err_sop is set if din_valid & din_sop arrives with beat counter != 0, or if the first beat lacks din_sop. The beat is still counted.
  - Timeout: the timeout counter reaching TIMEOUT-1 sets err_timeout, decrements pending, leaves pkt_done unchanged, and goes to GAP.
  - A beat with sop and eop together is a 1-beat packet; it is legal only when BEAT_NUM==1.
- GAP: a counter runs GAP_CYCLES cycles, then the FSM goes to IDLE. The next packet can start GAP_CYCLES+1 cycles after eop.
- Deassertion of enable never aborts a packet in progress. The FSM finishes the packet and gap, then stays in IDLE.
- Pending counter:
  - +1 on pkt_ready, -1 on completion or timeout; both in the same cycle leaves it unchanged.
  - pkt_ready while pending==MAX_PENDING with no decrement that cycle: the counter holds and err_overflow is set.
  - A decrement with pending==0 cannot occur, because READ requires pending!=0.
- Error flags are sticky until clear_err. If clear_err and a new error arrive in the same cycle, the flag ends set.
- din_valid outside READ is ignored; no counter changes and no flag is set.

Test Plan:
- Bench uses BEAT_NUM=4, GAP_CYCLES=2, TIMEOUT=8, MAX_PENDING=3.
- Basic read: enable=1, sink_ready=1, one pkt_ready, buffer returns 4 beats (sop on beat 1, eop on beat 4) -> data_rd_req high from the cycle after IDLE->READ until eop; then pending=0, pkt_done=1, no error flags, state IDLE after 2 gap cycles.
- Back-to-back: 3 pkt_ready pulses, then 4 pkt_ready with no reads -> pending saturates at 3 and err_overflow=1; draining 3 packets gives pkt_done=3, pending=0; clear_err -> status[15:12]=0.
- Timeout: pending=1, buffer never asserts din_valid -> after 8 cycles in READ, err_timeout=1, pending=0, pkt_done=0, FSM passes GAP then IDLE. With sink_ready=0 held for 20 cycles there is no timeout.
- Framing errors: a 3-beat packet -> err_len=1 at eop; a 5-beat packet with a second sop on beat 3 -> err_sop=1 and err_len=1.
- Simultaneous events: pkt_ready in the same cycle as eop -> pending unchanged. enable deasserted mid-packet -> packet completes and the FSM then stays IDLE with pending preserved.
- Reset mid-read (rst_n low on beat 2) -> all outputs 0 in the same cycle; after release the FSM is IDLE with pending=0.
